// File: rtl/bram_read_streamer_pkg.sv
// Shared definitions for the BRAM read streamer.
// Optional tag support is selected with the macro BRAM_READ_STREAMER_TAG_EN.
package bram_read_streamer_pkg;

  // Cycles from an accepted request to registered data on bram_dout
  localparam int READ_LATENCY = 2;

  // Field widths of the response record in the default configuration
  localparam int RESP_DATA_W = 18;
  localparam int RESP_TAG_W  = 4;

  // One response as seen by the consumer
  typedef struct packed {
`ifdef BRAM_READ_STREAMER_TAG_EN
    logic [RESP_TAG_W-1:0]  tag;
`endif
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/bram_read_streamer_stream_fifo.sv
// Synchronous response FIFO used by the BRAM read streamer.
// Storage is not reset; only pointers and occupancy are.
module stream_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [PTR_W:0]   count_d, count_q;
  logic             do_push, do_pop;

  // Qualify push/pop and compute next pointers and occupancy
  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A pop in the same cycle frees the slot the incoming word needs
    do_push  = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/bram_read_streamer.sv
// Streams read requests into a 2-cycle registered BRAM and returns the words
// in order through a credit-controlled response FIFO.
// Define BRAM_READ_STREAMER_TAG_EN to carry a per-request tag to resp_tag.
module bram_read_streamer
  import bram_read_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_regce,
  output logic                  bram_reset,
  input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef BRAM_READ_STREAMER_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [TAG_WIDTH-1:0]  resp_tag
`endif
);

`ifdef BRAM_READ_STREAMER_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  localparam int ENTRY_W = DATA_WIDTH + (TAG_EN ? TAG_WIDTH : 0);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  // Outstanding = buffered words plus reads still inside the BRAM
  localparam int OUT_W   = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  logic               accept;
  logic [OUT_W-1:0]   outstanding;
  logic               vld_p1_d, vld_p1_q;
  logic               vld_p2_d, vld_p2_q;
  logic [ENTRY_W-1:0] push_data, pop_data;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Stage p0: credit check from registered state, issue the BRAM read
  always_comb begin
    outstanding = OUT_W'(fifo_count) + OUT_W'(vld_p1_q) + OUT_W'(vld_p2_q);
    req_ready   = reset_n && !fifo_full && (outstanding < OUT_W'(FIFO_DEPTH));
    accept      = req_valid && req_ready;
    vld_p1_d    = accept;
    vld_p2_d    = vld_p1_q;
  end

  // Stages p1/p2: valid shift register following each read through the BRAM
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

`ifdef BRAM_READ_STREAMER_TAG_EN
  logic [TAG_WIDTH-1:0] tag_p1_d, tag_p1_q;
  logic [TAG_WIDTH-1:0] tag_p2_d, tag_p2_q;

  // Tags ride the same two stages so each meets its word at the FIFO
  always_comb begin
    tag_p1_d = req_tag;
    tag_p2_d = tag_p1_q;
  end

  // Tag pipeline registers (data only, no reset)
  always_ff @(posedge clock) begin
    tag_p1_q <= tag_p1_d;
    tag_p2_q <= tag_p2_d;
  end

  assign push_data = {tag_p2_q, bram_dout};
  assign resp_tag  = pop_data[ENTRY_W-1:DATA_WIDTH];
`else
  assign push_data = bram_dout;
`endif

  assign bram_en    = accept;
  assign bram_addr  = req_addr;
  assign bram_regce = vld_p1_q;
  assign bram_reset = ~reset_n;

  // Stage p3: response buffer; credits guarantee room for every arriving word
  stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (vld_p2_q),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = reset_n && !fifo_empty;
  assign resp_data  = pop_data[DATA_WIDTH-1:0];
  assign fifo_pop   = resp_valid && resp_ready;

endmodule

// File: tb/tb_bram_read_streamer.sv
// Self-checking bench for bram_read_streamer: BRAM behavioural model,
// queue scoreboard of accepted requests, directed scenarios and random traffic.
module tb_bram_read_streamer;
  import bram_read_streamer_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic          bram_regce;
  logic          bram_reset;
  logic [DW-1:0] bram_dout;
`ifdef BRAM_READ_STREAMER_TAG_EN
  logic [TW-1:0] req_tag = '0;
  logic [TW-1:0] resp_tag;
`endif

  bram_read_streamer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .TAG_WIDTH  (TW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_regce (bram_regce),
    .bram_reset (bram_reset),
    .bram_dout  (bram_dout)
`ifdef BRAM_READ_STREAMER_TAG_EN
    ,
    .req_tag    (req_tag),
    .resp_tag   (resp_tag)
`endif
  );

  always #5 clock = ~clock;

  // BRAM: address latched on bram_en, output register loaded on bram_regce
  logic [DW-1:0] mem [1024];
  logic [AW-1:0] bram_addr_r;
  logic [DW-1:0] dout_r;
  always @(posedge clock) begin
    if (bram_en) bram_addr_r <= bram_addr;
    if (bram_reset) dout_r <= '0;
    else if (bram_regce) dout_r <= mem[bram_addr_r];
  end
  assign bram_dout = dout_r;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted request owes exactly one response, in order
  resp_t exp_q[$];
  int    n_resp = 0;
  logic  prev_acc = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_bram_reset", bram_reset, 1);
      exp_q.delete();
      prev_acc = 1'b0;
    end else begin
      check("bram_reset", bram_reset, 0);
      check("req_ready_credit", req_ready, exp_q.size() < DEPTH);
      check("bram_en", bram_en, req_valid && (exp_q.size() < DEPTH));
      check("bram_addr", bram_addr, req_addr);
      check("bram_regce", bram_regce, prev_acc);
      if (resp_valid && resp_ready) begin
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          resp_t e;
          e = exp_q.pop_front();
          check("resp_data", resp_data, e.data);
`ifdef BRAM_READ_STREAMER_TAG_EN
          check("resp_tag", resp_tag, e.tag);
`endif
          n_resp++;
        end
      end
      prev_acc = req_valid && req_ready;
      if (prev_acc) begin
        resp_t n;
        n.data = mem[req_addr];
`ifdef BRAM_READ_STREAMER_TAG_EN
        n.tag = req_tag;
`endif
        exp_q.push_back(n);
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int i;
    int cyc;
    logic acc;
    logic found;
    for (int k = 0; k < 1024; k++) mem[k] = DW'($urandom);
    mem[5] = 18'h2A;
    mem[6] = 18'h15;

    // Reset and first cycle after it
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);
    check("valid_after_reset", resp_valid, 0);

    // Back-to-back reads of 5 and 6, latency 3 from acceptance
    next();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 10'd5;
    @(negedge clock);
    check("s1_acc0", req_ready, 1);
    next();
    req_addr = 10'd6;
    @(negedge clock);
    check("s1_acc1", req_ready, 1);
    check("s1_t1_valid", resp_valid, 0);
    next();
    req_valid = 1'b0;
    @(negedge clock);
    check("s1_t2_valid", resp_valid, 0);
    next();
    @(negedge clock);
    check("s1_t3_valid", resp_valid, 1);
    check("s1_t3_data", resp_data, 18'h2A);
    next();
    @(negedge clock);
    check("s1_t4_valid", resp_valid, 1);
    check("s1_t4_data", resp_data, 18'h15);
    next();
    @(negedge clock);
    check("s1_t5_valid", resp_valid, 0);

    // Backpressure: only DEPTH accepts while the consumer stalls
    next();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      req_addr = AW'($urandom);
      @(negedge clock);
      if (req_ready) n++;
      next();
    end
    check("s2_accepts", n, DEPTH);
    @(negedge clock);
    check("s2_ready_low", req_ready, 0);
    next();
    req_valid  = 1'b0;
    r0 = n_resp;
    resp_ready = 1'b1;
    repeat (12) next();
    check("s2_resp_count", n_resp - r0, DEPTH);
    @(negedge clock);
    check("s2_ready_back", req_ready, 1);

    // Streaming 0..15 with resp_ready toggling every cycle
    next();
    r0 = n_resp;
    i = 0;
    cyc = 0;
    req_valid = 1'b1;
    while (i < 16 && cyc < 200) begin
      req_addr   = AW'(i);
      resp_ready = ~resp_ready;
      @(negedge clock);
      acc = req_ready;
      next();
      if (acc) i++;
      cyc++;
    end
    req_valid = 1'b0;
    check("s3_accepts", i, 16);
    repeat (40) begin
      resp_ready = ~resp_ready;
      next();
    end
    check("s3_resp_count", n_resp - r0, 16);

    // Reset with two reads in flight
    resp_ready = 1'b1;
    next();
    req_valid = 1'b1;
    req_addr  = 10'd7;
    next();
    req_addr  = 10'd8;
    next();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    next();
    reset_n   = 1'b1;
    r0 = n_resp;
    @(negedge clock);
    check("s4_ready_after_rst", req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("s4_no_stale", resp_valid, 0);
      next();
    end
    check("s4_no_resp", n_resp - r0, 0);
    req_valid = 1'b1;
    req_addr  = 10'd3;
    next();
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (resp_valid && !found) begin
        check("s4_addr3_data", resp_data, mem[3]);
        found = 1'b1;
      end
      next();
    end
    check("s4_addr3_seen", found, 1);

`ifdef BRAM_READ_STREAMER_TAG_EN
    // Tags 0xA,0xB,0xC on addresses 1,2,3
    begin
      logic [TW-1:0] tags [3];
      int j;
      tags[0] = 4'hA;
      tags[1] = 4'hB;
      tags[2] = 4'hC;
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        req_addr = AW'(k + 1);
        req_tag  = tags[k];
        next();
      end
      req_valid = 1'b0;
      j = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clock);
        if (resp_valid && j < 3) begin
          check("s5_tag", resp_tag, tags[j]);
          check("s5_data", resp_data, mem[j + 1]);
          j++;
        end
        next();
      end
      check("s5_count", j, 3);
    end
`endif

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
`ifdef BRAM_READ_STREAMER_TAG_EN
      req_tag    = TW'($urandom);
`endif
      next();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (20) next();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bram_read_streamer.md
BRAM_READ_STREAMER -- requirements
Module: bram_read_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 18, BRAM word width.
REQ-003 Parameter FIFO_DEPTH, default 4, response buffer entries; power of two, at least 2.
REQ-004 Parameter TAG_WIDTH, default 4, request tag width; used only with the tag feature.
REQ-005 Ports, in this order (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  read request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  ADDR_WIDTH  read address.
- resp_valid  out  1  response data valid.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DATA_WIDTH  read word.
- bram_en  out  1  BRAM read-port enable.
- bram_addr  out  ADDR_WIDTH  BRAM read-port address.
- bram_regce  out  1  BRAM output-register enable.
- bram_reset  out  1  active-high BRAM output-register reset.
- bram_dout  in  DATA_WIDTH  BRAM registered read data.

Function
REQ-006 A request SHALL be accepted when req_valid and req_ready are both high at a rising clock edge.
REQ-007 bram_en SHALL equal req_valid AND req_ready, and bram_addr SHALL equal req_addr (combinational).
REQ-008 The BRAM read latency SHALL be 2 cycles: if accepted in cycle t, bram_regce SHALL be high in cycle t+1 and bram_dout SHALL be sampled into the FIFO at the end of cycle t+2.
REQ-009 In-flight tracking SHALL use a 2-stage valid shift register; bram_regce SHALL equal stage-1 valid.
REQ-010 req_ready SHALL be high only while (FIFO occupancy + in-flight count) < FIFO_DEPTH.
REQ-011 Credits SHALL be computed from registered state only, so req_ready does not depend on req_valid or resp_ready.
REQ-012 resp_valid SHALL equal FIFO not-empty, and resp_data SHALL be the FIFO head.
REQ-013 Responses SHALL be returned strictly in request order.
REQ-014 A simultaneous FIFO push and pop SHALL leave the occupancy unchanged; a pop at full occupancy plus an arriving word SHALL NOT overflow.
REQ-015 With resp_ready held high, throughput SHALL be one request per cycle sustained, with 3 cycles from acceptance to resp_valid.
REQ-016 With resp_ready held low, at most FIFO_DEPTH requests SHALL be accepted, and then req_ready SHALL be low.

Reset
REQ-017 While reset_n is low at an edge, the following SHALL hold:
- pipeline valid bits and the FIFO SHALL be cleared;
- req_ready SHALL be 0 during reset and 1 in the first cycle after;
- resp_valid SHALL be 0.
REQ-018 bram_reset SHALL be the inverse of reset_n.
REQ-019 Reset mid-operation SHALL discard in-flight reads, and no response for them SHALL appear afterwards.

Configuration
REQ-020 Macro BRAM_READ_STREAMER_TAG_EN: when defined, the following SHALL hold:
- ports req_tag (in, TAG_WIDTH) and resp_tag (out, TAG_WIDTH) SHALL exist;
- each tag SHALL travel with its request through the pipeline and FIFO;
- resp_tag SHALL be valid with resp_data.
REQ-021 Without the macro, those ports and their storage SHALL be absent, with behaviour otherwise identical.

Structure
REQ-022 A shared package SHALL hold the read-latency constant (2) and a response struct typedef (data, plus tag when enabled).
REQ-023 The response buffer SHALL be a separate synchronous FIFO sub-module named stream_fifo, with push, pop, full, empty and count ports.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Preload mem[5]=0x2A and mem[6]=0x15, issue addr 5 then 6 back-to-back with resp_ready=1 -> 0x2A then 0x15 on consecutive cycles, first 3 cycles after acceptance.
- resp_ready=0 and req_valid held high -> exactly 4 accepts, then req_ready=0; release resp_ready -> 4 ordered responses, then req_ready returns to 1.
- resp_ready toggled every cycle over 16 streaming requests to addresses 0..15 -> all 16 words in order, no loss or duplication.
- reset_n low for 1 cycle with 2 reads in flight -> resp_valid=0 and no stale data afterwards; the next read of addr 3 returns mem[3].
- TAG_EN build with tags 0xA,0xB,0xC on addrs 1,2,3 -> resp_tag follows the same sequence, each aligned with its data.
